// File: rtl/display_to_map_index.sv
// Maps a scan position to its tile in the map matrix, using a two-stage pipeline.
// Outputs: tile column/row, offset inside the tile, row-major map RAM address and tile strobes.
module display_to_map_index #(
  parameter int H_VISIBLE_START = 336,
  parameter int V_VISIBLE_START = 27,
  parameter int MOVE_TO_CENTER  = 7,
  parameter int MAP_COLS        = 80
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pixel_en,
  input  logic [10:0] display_pos_x,
  input  logic [9:0]  display_pos_y,
  output logic        idx_valid,
  output logic [6:0]  matrix_idx_x,
  output logic [5:0]  matrix_idx_y,
  output logic [3:0]  tile_off_x,
  output logic [3:0]  tile_off_y,
  output logic [11:0] map_addr,
  output logic        map_rd,
  output logic        tile_start,
  output logic        tile_center,
  output logic        frame_done
);

  localparam int MAP_ROWS = 50;
  localparam int H_LAST   = H_VISIBLE_START + MAP_COLS * 16 - 1;
  localparam int V_LAST   = V_VISIBLE_START + MAP_ROWS * 16 - 1;

  localparam logic [11:0] H_LO       = 12'(H_VISIBLE_START);
  localparam logic [11:0] H_HI       = 12'(H_LAST);
  localparam logic [10:0] V_LO       = 11'(V_VISIBLE_START);
  localparam logic [10:0] V_HI       = 11'(V_LAST);
  localparam logic [10:0] REL_X_LAST = 11'(MAP_COLS * 16 - 1);
  localparam logic [9:0]  REL_Y_LAST = 10'(MAP_ROWS * 16 - 1);
  localparam logic [3:0]  CENTER     = 4'(MOVE_TO_CENTER);
  localparam logic [6:0]  COLS       = 7'(MAP_COLS);

  // Stage 1: range check and offset removal
  logic        in_range;
  logic        s1_valid_reg;
  logic [10:0] rel_x_reg;
  logic [9:0]  rel_y_reg;

  // Zero-extended compares so an underflowing position is never seen as in range
  assign in_range = pixel_en
                 && ({1'b0, display_pos_x} >= H_LO) && ({1'b0, display_pos_x} <= H_HI)
                 && ({1'b0, display_pos_y} >= V_LO) && ({1'b0, display_pos_y} <= V_HI);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      rel_x_reg    <= '0;
      rel_y_reg    <= '0;
    end else begin
      s1_valid_reg <= in_range;
      rel_x_reg    <= display_pos_x - H_LO[10:0];
      rel_y_reg    <= display_pos_y - V_LO[9:0];
    end
  end

  // Stage 2 combinational terms
  logic [6:0]  idx_x_next;
  logic [5:0]  idx_y_next;
  logic [11:0] addr_terms [7];
  logic [11:0] addr_next;
  logic        tile_start_next;
  logic        tile_center_next;
  logic        frame_hit_next;

  assign idx_x_next = rel_x_reg[10:4];
  assign idx_y_next = rel_y_reg[9:4];

  // Row stride as a constant shift-and-add over the set bits of MAP_COLS
  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_addr_term
      assign addr_terms[gi] = COLS[gi] ? (12'(idx_y_next) << gi) : 12'd0;
    end
  endgenerate

  always_comb begin
    addr_next = 12'(idx_x_next);
    for (int i = 0; i < 7; i++) begin
      addr_next = addr_next + addr_terms[i];
    end
  end

  assign tile_start_next  = s1_valid_reg && (rel_x_reg[3:0] == 4'd0);
  assign tile_center_next = s1_valid_reg && (rel_x_reg[3:0] == CENTER) && (rel_y_reg[3:0] == CENTER);
  assign frame_hit_next   = s1_valid_reg && (rel_x_reg == REL_X_LAST) && (rel_y_reg == REL_Y_LAST);

  // Stage 2: registered outputs; index/offset/address hold across invalid samples
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_valid    <= 1'b0;
      matrix_idx_x <= '0;
      matrix_idx_y <= '0;
      tile_off_x   <= '0;
      tile_off_y   <= '0;
      map_addr     <= '0;
      map_rd       <= 1'b0;
      tile_start   <= 1'b0;
      tile_center  <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      idx_valid   <= s1_valid_reg;
      // idx_valid still holds the previous sample here, so !idx_valid marks a gap
      map_rd      <= s1_valid_reg && ((rel_x_reg[3:0] == 4'd0) || !idx_valid);
      tile_start  <= tile_start_next;
      tile_center <= tile_center_next;
      frame_done  <= frame_hit_next;
      if (s1_valid_reg) begin
        matrix_idx_x <= idx_x_next;
        matrix_idx_y <= idx_y_next;
        tile_off_x   <= rel_x_reg[3:0];
        tile_off_y   <= rel_y_reg[3:0];
        map_addr     <= addr_next;
      end
    end
  end

endmodule

// File: tb/tb_display_to_map_index.sv
// Scoreboard bench for display_to_map_index: a reference model queues the expected outputs per sample,
// and they are compared when that sample leaves the pipeline.
module tb_display_to_map_index;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pixel_en = 1'b0;
  logic [10:0] display_pos_x = '0;
  logic [9:0]  display_pos_y = '0;
  logic        idx_valid;
  logic [6:0]  matrix_idx_x;
  logic [5:0]  matrix_idx_y;
  logic [3:0]  tile_off_x;
  logic [3:0]  tile_off_y;
  logic [11:0] map_addr;
  logic        map_rd;
  logic        tile_start;
  logic        tile_center;
  logic        frame_done;

  display_to_map_index dut (
    .clk(clk), .rst(rst), .pixel_en(pixel_en),
    .display_pos_x(display_pos_x), .display_pos_y(display_pos_y),
    .idx_valid(idx_valid), .matrix_idx_x(matrix_idx_x), .matrix_idx_y(matrix_idx_y),
    .tile_off_x(tile_off_x), .tile_off_y(tile_off_y), .map_addr(map_addr),
    .map_rd(map_rd), .tile_start(tile_start), .tile_center(tile_center), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          due;
    int          x;
    int          y;
    logic [37:0] vec;
  } exp_t;
  exp_t sb[$];

  // Reference model state
  bit          m_prev_v = 1'b0;
  logic [6:0]  m_ix = '0;
  logic [5:0]  m_iy = '0;
  logic [3:0]  m_ox = '0;
  logic [3:0]  m_oy = '0;
  logic [11:0] m_addr = '0;

  function automatic logic [37:0] out_vec();
    return {idx_valid, matrix_idx_x, matrix_idx_y, tile_off_x, tile_off_y, map_addr,
            map_rd, tile_start, tile_center, frame_done};
  endfunction

  task automatic model_reset();
    m_prev_v = 1'b0;
    m_ix = '0; m_iy = '0; m_ox = '0; m_oy = '0; m_addr = '0;
    sb.delete();
  endtask

  // One clock: drive a sample, queue its expected result, retire whatever is due
  task automatic cycle(input int x, input int y, input bit en);
    exp_t e;
    bit v;
    bit rd, ts, tc, fd;
    int rx, ry;
    display_pos_x = 11'(x);
    display_pos_y = 10'(y);
    pixel_en      = en;
    v  = en && (x >= 336) && (x <= 1615) && (y >= 27) && (y <= 826);
    rx = x - 336;
    ry = y - 27;
    if (v) begin
      m_ix   = 7'(rx / 16);
      m_iy   = 6'(ry / 16);
      m_ox   = 4'(rx % 16);
      m_oy   = 4'(ry % 16);
      m_addr = 12'((ry / 16) * 80 + rx / 16);
    end
    rd = v && ((rx % 16 == 0) || !m_prev_v);
    ts = v && (rx % 16 == 0);
    tc = v && (rx % 16 == 7) && (ry % 16 == 7);
    fd = v && (rx == 1279) && (ry == 799);
    m_prev_v = v;
    e.due = edge_cnt + 2;
    e.x   = x;
    e.y   = y;
    e.vec = {v, m_ix, m_iy, m_ox, m_oy, m_addr, rd, ts, tc, fd};
    sb.push_back(e);
    @(posedge clk); #1;
    while (sb.size() > 0 && sb[0].due == edge_cnt) begin
      e = sb.pop_front();
      checks++;
      if (out_vec() !== e.vec) begin
        errors++;
        $display("FAIL sample(%0d,%0d) got=%h exp=%h", e.x, e.y, out_vec(), e.vec);
      end
    end
  endtask

  task automatic rst_cycle(input int x, input int y, input bit en);
    rst = 1'b1;
    display_pos_x = 11'(x);
    display_pos_y = 10'(y);
    pixel_en = en;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_cycle(336, 27, 1'b1);
    rst_cycle(336, 27, 1'b1);
    rst = 1'b0;
    checks++;
    if (out_vec() !== 38'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0", out_vec());
    end
    $display("test_reset done");
  endtask

  task automatic test_corners();
    int fd_cnt = 0;
    cycle(336, 27, 1'b1);
    cycle(343, 34, 1'b1);
    cycle(1615, 826, 1'b1);
    if (frame_done) fd_cnt++;
    cycle(0, 0, 1'b0);
    if (frame_done) fd_cnt++;
    cycle(0, 0, 1'b0);
    if (frame_done) fd_cnt++;
    checks++;
    if (fd_cnt != 1) begin
      errors++;
      $display("FAIL corner_frame_done got=%0d exp=1", fd_cnt);
    end
    $display("test_corners done");
  endtask

  task automatic test_boundaries();
    int bx[6] = '{500, 335, 1616, 336, 336, 0};
    int by[6] = '{300, 27, 27, 26, 827, 0};
    for (int i = 0; i < 6; i++) cycle(bx[i], by[i], 1'b1);
    cycle(400, 100, 1'b0);
    cycle(0, 0, 1'b0);
    cycle(0, 0, 1'b0);
    checks++;
    if ({matrix_idx_x, matrix_idx_y} !== {7'((500 - 336) / 16), 6'((300 - 27) / 16)}) begin
      errors++;
      $display("FAIL boundary_hold got=(%0d,%0d) exp=(%0d,%0d)", matrix_idx_x, matrix_idx_y,
               (500 - 336) / 16, (300 - 27) / 16);
    end
    $display("test_boundaries done");
  endtask

  task automatic test_full_line();
    int rd_cnt = 0;
    int v_cnt = 0;
    cycle(0, 0, 1'b0);
    cycle(0, 0, 1'b0);
    for (int k = 0; k < 1282; k++) begin
      if (k < 1280) cycle(336 + k, 27, 1'b1);
      else cycle(0, 0, 1'b0);
      if (idx_valid) v_cnt++;
      if (map_rd) begin
        checks++;
        if (map_addr !== 12'(rd_cnt)) begin
          errors++;
          $display("FAIL line_addr_order got=%0d exp=%0d", map_addr, rd_cnt);
        end
        rd_cnt++;
      end
    end
    checks++;
    if (rd_cnt != 80) begin
      errors++;
      $display("FAIL line_map_rd_count got=%0d exp=80", rd_cnt);
    end
    checks++;
    if (v_cnt != 1280) begin
      errors++;
      $display("FAIL line_valid_count got=%0d exp=1280", v_cnt);
    end
    $display("test_full_line done");
  endtask

  task automatic test_back_to_back();
    int fd_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (k < 3) cycle(1615, 826, 1'b1);
      else cycle(0, 0, 1'b0);
      if (frame_done) fd_cnt++;
    end
    checks++;
    if (fd_cnt != 3) begin
      errors++;
      $display("FAIL repeat_frame_done got=%0d exp=3", fd_cnt);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_midstream();
    int bad = 0;
    cycle(336, 27, 1'b1);
    cycle(337, 27, 1'b1);
    rst_cycle(338, 27, 1'b1);
    if (idx_valid || map_rd || frame_done) bad++;
    rst_cycle(339, 27, 1'b1);
    if (idx_valid || map_rd || frame_done) bad++;
    rst_cycle(340, 27, 1'b1);
    if (idx_valid || map_rd || frame_done) bad++;
    rst = 1'b0;
    checks++;
    if (bad != 0 || out_vec() !== 38'd0) begin
      errors++;
      $display("FAIL midstream_reset got=%h strobes=%0d exp=0", out_vec(), bad);
    end
    cycle(352, 43, 1'b1);
    cycle(0, 0, 1'b0);
    checks++;
    if ({idx_valid, matrix_idx_x, matrix_idx_y, map_addr} !== {1'b1, 7'd1, 6'd1, 12'd81}) begin
      errors++;
      $display("FAIL restart got=v%0d (%0d,%0d) addr=%0d exp=v1 (1,1) addr=81",
               idx_valid, matrix_idx_x, matrix_idx_y, map_addr);
    end
    cycle(0, 0, 1'b0);
    $display("test_reset_midstream done");
  endtask

  task automatic test_random_center();
    int ix, iy, fx, fy;
    for (int n = 0; n < 20; n++) begin
      ix = int'($urandom_range(0, 79));
      iy = int'($urandom_range(0, 49));
      cycle(336 + ix * 16 + 7, 27 + iy * 16 + 7, 1'b1);
      cycle(0, 0, 1'b0);
      fx = (int'(matrix_idx_x) << 4) + 7;
      fy = (int'(matrix_idx_y) << 4) + 7;
      checks++;
      if (!tile_center || fx != ix * 16 + 7 || fy != iy * 16 + 7) begin
        errors++;
        $display("FAIL inverse_map got=tc%0d (%0d,%0d) exp=tc1 (%0d,%0d)",
                 tile_center, fx, fy, ix * 16 + 7, iy * 16 + 7);
      end
    end
    cycle(0, 0, 1'b0);
    cycle(0, 0, 1'b0);
    $display("test_random_center done");
  endtask

  initial begin
    test_reset();
    test_corners();
    test_boundaries();
    test_full_line();
    test_back_to_back();
    test_reset_midstream();
    test_random_center();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
